// File: rtl/demux4b_pkg.sv
// demux4b_pkg: shared constants and types for the 1-to-4 registered demux
package demux4b_pkg;
  localparam int NCH = 4;
  localparam int W = 4;
  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR = 1'b1;
  typedef logic [1:0] chan_idx_t;
endpackage

// File: rtl/demux4b_seq_slot.sv
// demux_slot: one-entry output register with valid/ready flow control
module demux_slot #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  input  logic         out_ready,
  output logic         ready,
  output logic [W-1:0] y,
  output logic         valid
);
  logic         valid_q, valid_d;
  logic [W-1:0] y_q, y_d;
  always_comb begin
    ready = !valid_q | out_ready;
    valid_d = load | (valid_q & !out_ready);
    y_d = load ? d : y_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      y_q <= '0;
    end else begin
      valid_q <= valid_d;
      y_q <= y_d;
    end
  end
  assign valid = valid_q;
  assign y = y_q;
endmodule

// File: rtl/demux4b_seq.sv
// demux4b_seq: registered 1-to-4 demux with explicit-select or round-robin targeting
module demux4b_seq
  import demux4b_pkg::*;
#(
  parameter int W = demux4b_pkg::W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  input  logic [1:0]   s,
  input  logic         rr,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] y0,
  output logic [W-1:0] y1,
  output logic [W-1:0] y2,
  output logic [W-1:0] y3,
  output logic [3:0]   out_valid,
  input  logic [3:0]   out_ready,
  output logic [1:0]   ptr,
  output logic [7:0]   count
);
  logic [W-1:0]   y [NCH];
  logic [NCH-1:0] rdy, ld;
  chan_idx_t      t, ptr_q, ptr_d;
  logic [7:0]     count_q, count_d;
  logic           acc;
  always_comb begin
    t = (rr == MODE_RR) ? ptr_q : s;
    in_ready = rdy[t];
    acc = in_valid & in_ready;
    ld = '0;
    ld[t] = acc;
    ptr_d = (acc && rr == MODE_RR) ? ptr_q + 2'd1 : ptr_q;
    count_d = count_q + {7'd0, acc};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
      count_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      count_q <= count_d;
    end
  end
  for (genvar i = 0; i < NCH; i++) begin : g_slot
    demux_slot #(.W(W)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (ld[i]),
      .d         (d),
      .out_ready (out_ready[i]),
      .ready     (rdy[i]),
      .y         (y[i]),
      .valid     (out_valid[i])
    );
  end
  assign y0 = y[0];
  assign y1 = y[1];
  assign y2 = y[2];
  assign y3 = y[3];
  assign ptr = ptr_q;
  assign count = count_q;
endmodule

// File: tb/tb_demux4b_seq.sv
// tb_demux4b_seq: directed self-checking bench for demux4b_seq
module tb_demux4b_seq;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] d;
  logic [1:0] s;
  logic       rr;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] y0, y1, y2, y3;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [1:0] ptr;
  logic [7:0] count;
  int n_chk = 0;
  int n_fail = 0;

  demux4b_seq #(.W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .d         (d),
    .s         (s),
    .rr        (rr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y0        (y0),
    .y1        (y1),
    .y2        (y2),
    .y3        (y3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ptr       (ptr),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; d = '0; s = '0; rr = 1'b0; in_valid = 1'b0; out_ready = '0;
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("rst_valid", out_valid, 4'b0000);
    chk("rst_ptr", ptr, 0);
    chk("rst_count", count, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_y", {y3, y2, y1, y0}, 16'h0000);

    rr = 1'b0; s = 2'd2; d = 4'b1010; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("sel_valid", out_valid, 4'b0100);
    chk("sel_y2", y2, 4'b1010);
    chk("sel_count", count, 1);
    chk("sel_ptr", ptr, 0);

    d = 4'b0101; in_valid = 1'b1;
    #1;
    chk("full_ready", in_ready, 0);
    step();
    chk("full_hold_y2", y2, 4'b1010);
    chk("full_hold_cnt", count, 1);
    chk("full_hold_valid", out_valid, 4'b0100);
    out_ready = 4'b0100;
    #1;
    chk("drain_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("reload_y2", y2, 4'b0101);
    chk("reload_valid", out_valid, 4'b0100);
    chk("reload_count", count, 2);

    rr = 1'b1; out_ready = 4'b1111;
    for (int k = 1; k <= 5; k++) begin
      d = 4'(k); in_valid = 1'b1;
      #1;
      chk("rr_ptr", ptr, (k - 1) % 4);
      step();
    end
    in_valid = 1'b0;
    chk("rr_ptr_end", ptr, 1);
    chk("rr_count", count, 7);
    chk("rr_valid", out_valid, 4'b0001);
    chk("rr_y", {y3, y2, y1, y0}, 16'h4325);
    step();
    chk("rr_drained", out_valid, 4'b0000);

    rr = 1'b0; s = 2'd1; d = 4'h7; in_valid = 1'b1; out_ready = 4'b0000;
    step();
    chk("sel_no_ptr", ptr, 1);
    chk("slot1_full", out_valid, 4'b0010);
    rr = 1'b1; d = 4'h9;
    #1;
    chk("stall_ready", in_ready, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_ptr", ptr, 1);
      chk("stall_count", count, 8);
    end
    out_ready = 4'b0010;
    #1;
    chk("resume_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("resume_ptr", ptr, 2);
    chk("resume_y1", y1, 4'h9);
    chk("resume_valid", out_valid, 4'b0010);
    chk("resume_count", count, 9);
    out_ready = 4'b1111;
    step();

    rr = 1'b0; s = 2'd0; d = 4'h3; in_valid = 1'b1;
    repeat (246) step();
    chk("cnt_255", count, 255);
    step();
    in_valid = 1'b0;
    chk("cnt_wrap", count, 0);
    step();
    chk("pre_rst_empty", out_valid, 4'b0000);

    out_ready = 4'b0000; d = 4'hC; s = 2'd0; in_valid = 1'b1;
    step();
    s = 2'd3;
    step();
    chk("two_full", out_valid, 4'b1001);
    chk("two_count", count, 2);
    chk("two_ptr", ptr, 2);
    rst_n = 1'b0; s = 2'd1; d = 4'hF; in_valid = 1'b1;
    step();
    chk("mid_rst_valid", out_valid, 4'b0000);
    chk("mid_rst_y", {y3, y2, y1, y0}, 16'h0000);
    chk("mid_rst_ptr", ptr, 0);
    chk("mid_rst_count", count, 0);
    in_valid = 1'b0; rst_n = 1'b1;
    step();
    chk("post_rst_valid", out_valid, 4'b0000);
    chk("post_rst_count", count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
